// File: rtl/din_debounce.sv
// Debounce conditioner for a raw asynchronous input: synchroniser, four-state
// qualify FSM with hold counter, registered level plus single-cycle rise/fall pulses.
module din_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            busy_q, busy_d;

  // Only the last synchroniser stage is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      StStableLo: begin
        cnt_d = '0;
        if (s) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (!s) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StStableHi;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStableHi: begin
        cnt_d = '0;
        if (!s) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (s) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StStableLo;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase

    // Registered decode of the next state so busy lines up with the WAIT states.
    busy_d = (state_d == StWaitHi) || (state_d == StWaitLo);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StStableLo;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_din_debounce.sv
// Directed bench for din_debounce: main instance SYNC_STAGES=2/DEBOUNCE_CYCLES=4,
// second instance SYNC_STAGES=3/DEBOUNCE_CYCLES=1 for the parameter sweep.
module tb_din_debounce;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic din2;
  logic level, rise, fall, busy;
  logic level2, rise2, fall2, busy2;

  int vectors = 0;
  int miscompares = 0;
  int rise_cnt;

  always #5 clk = ~clk;

  din_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  din_debounce #(
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(1)
  ) dut2 (
    .clk  (clk),
    .rst  (rst),
    .din  (din2),
    .level(level2),
    .rise (rise2),
    .fall (fall2),
    .busy (busy2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    din  = 1'b0;
    din2 = 1'b0;

    // Reset state
    #2;
    chk("reset level", level, 1'b0);
    chk("reset rise", rise, 1'b0);
    chk("reset fall", fall, 1'b0);
    chk("reset busy", busy, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("idle level", level, 1'b0);
    chk("idle busy", busy, 1'b0);

    // Clean rise on both instances
    din  = 1'b1;
    din2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("rise.level e%0d", e), level, e >= 7);
      chk($sformatf("rise.rise e%0d", e), rise, e == 7);
      chk($sformatf("rise.fall e%0d", e), fall, 1'b0);
      chk($sformatf("rise.busy e%0d", e), busy, (e >= 3) && (e <= 6));
      chk($sformatf("sweep.level e%0d", e), level2, e >= 5);
      chk($sformatf("sweep.rise e%0d", e), rise2, e == 5);
    end

    // Clean fall
    din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("fall.level e%0d", e), level, e < 7);
      chk($sformatf("fall.fall e%0d", e), fall, e == 7);
      chk($sformatf("fall.rise e%0d", e), rise, 1'b0);
      chk($sformatf("fall.busy e%0d", e), busy, (e >= 3) && (e <= 6));
    end

    // Bounce rejection: 1,0,1,0 then hold 0
    for (int e = 1; e <= 12; e++) begin
      din = (e == 1 || e == 3) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("bounce.level e%0d", e), level, 1'b0);
      chk($sformatf("bounce.rise e%0d", e), rise, 1'b0);
      chk($sformatf("bounce.fall e%0d", e), fall, 1'b0);
      chk($sformatf("bounce.busy e%0d", e), busy, (e == 3) || (e == 5));
    end

    // Bounce then settle: 1,1,1,0 then hold 1; final 0->1 sample is edge 5
    for (int e = 1; e <= 13; e++) begin
      din = (e == 4) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("settle.level e%0d", e), level, e >= 11);
      chk($sformatf("settle.rise e%0d", e), rise, e == 11);
      chk($sformatf("settle.busy e%0d", e), busy,
          ((e >= 3) && (e <= 5)) || ((e >= 7) && (e <= 10)));
    end

    // Asynchronous reset between edges while level is 1
    #3;
    rst = 1'b0;
    #1;
    chk("async.level", level, 1'b0);
    chk("async.rise", rise, 1'b0);
    chk("async.fall", fall, 1'b0);
    chk("async.busy", busy, 1'b0);
    chk("async.level2", level2, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // din held 1 across release: one rise, 7 edges later
    rise_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (rise === 1'b1) rise_cnt++;
      chk($sformatf("release.rise e%0d", e), rise, e == 7);
      chk($sformatf("release.level e%0d", e), level, e >= 7);
    end
    chk("release.single_rise", rise_cnt == 1, 1'b1);

    // Reset in the middle of a fall qualification
    din = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    chk("midq.busy_before", busy, 1'b1);
    chk("midq.level_before", level, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("midq.busy", busy, 1'b0);
    chk("midq.level", level, 1'b0);
    chk("midq.fall", fall, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("midq.after.level e%0d", e), level, 1'b0);
      chk($sformatf("midq.after.rise e%0d", e), rise, 1'b0);
      chk($sformatf("midq.after.fall e%0d", e), fall, 1'b0);
      chk($sformatf("midq.after.busy e%0d", e), busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
